fpn_normround_pipe: RTL and testbench
=====================================

Name: fpn_normround_pipe

Overview:
- Parametrised three-stage normalise-and-round pipeline for the FP units (32/64/80/128-bit formats).
- Takes the expanded intermediate result (sign, biased exponent, double-width significand) from an add, multiply or divide core.
- Produces a packed IEEE-style result, exception flags and quiet-NaN info codes.
- Valid/ready handshake on both sides, one result per clock, full backpressure.

Parameters:
FPWID, 80, total packed width
EMSB, 14, exponent MSB index (exponent is EMSB+1 bits)
FMSB, 63, stored significand MSB index (field is FMSB+1 bits)
EXPLICIT_INT, 1, 1 = leading one is stored at sig[FMSB] (80-bit); 0 = hidden bit
FX, (FMSB+2)*2, MSB index of expanded input significand

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input operand valid
i_ready  out  1  stage 1 can accept
i_sign  in  1  sign
i_exp  in  EMSB+2  biased exponent, extra MSB = overflow
i_sig  in  FX+1  expanded significand; leading one nominally at bit FX-1, bit FX = carry
i_nan  in  1  force quiet NaN
i_nan_info  in  4  NaN info code (1 subinf, 2 infdiv, 3 zerozero, 4 infzero, 5 sqrtinf, 6 sqrtneg)
i_rm  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
o_valid  out  1  result valid
o_ready  in  1  downstream accepts
o_res  out  FPWID  packed {sign, exp, sig}
o_inexact, o_overflow, o_underflow  out  1 each  exception flags aligned with o_res

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids are 0. o_valid=0, o_res=0, all flags 0, i_ready=1 after release.
- A reset asserted mid-operation discards all in-flight data. No partial result is emitted.
- Transfer on each side occurs when valid && ready in the same cycle.
- Stage k advances when it is empty or stage k+1 advances. Stage 3 advances when !o_valid || o_ready.
- i_ready = !v1 || advance1. This is combinational from o_ready through the stage chain.
- Latency is 3 clocks with no stall. Throughput is 1 per clock. Order is preserved; there is no loss and no duplication.
- Data registers hold their value while stalled.
- S1 (carry and leading-zero count):
  - If i_sig[FX]=1: shift right 1, exp+1, and OR the shifted-out bit into sticky.
  - Otherwise: lz = leading-zero count of sig[FX-1:0], width $clog2(FX+1).
  - Zero significand: result is signed zero, exp 0, inexact 0.
- S2 (normalise shift):
  - shift = min(lz, exp-1) when exp>0, else 0 (denormal support). Shift left by shift, exp -= shift.
  - If the leading bit is still 0 after the shift, exp becomes 0 (denormal) and the underflow candidate is set.
- S3 (round and pack):
  - Kept bits are FMSB+1 bits downward from bit FX-1. Guard is the next bit; sticky is the OR of all lower bits.
  - RNE increments on guard && (sticky || lsb). RMM increments on guard.
  - RUP increments on (guard||sticky) && !sign. RDN increments on (guard||sticky) && sign. RTZ never increments.
  - A significand carry-out from rounding sets exp+1 and re-normalises.
  - A denormal rounding up into the leading-one position sets exp=1.
  - inexact = guard || sticky.
- Overflow: exp >= all-ones after rounding sets overflow=1 and inexact=1.
  - RNE, RMM, and the directed mode toward the sign give infinity: exp all ones, sig = 100..0 if EXPLICIT_INT else 0.
  - RTZ and the directed mode away from the sign give max finite: exp all-ones minus 1, sig all ones.
- underflow = exp result 0 && inexact.
- i_nan=1 overrides everything:
  - exp all ones, sig top two bits 11 (EXPLICIT_INT) or top bit 1 (hidden), info code in sig[3:0], other bits 0.
  - Sign passes through. All flags 0.
- EXPLICIT_INT=0: the leading one is dropped and the field holds the next FMSB+1 bits.

Test Plan:
- FP80 RNE, i_exp=0x3FFF, i_sig bit129 only -> o_res=80'h3FFF_8000000000000000 on the 3rd clock after accept, all flags 0.
- i_exp=0x3FFF, i_sig bit130 only -> 80'h4000_8000000000000000 (2.0), no flags.
- i_sig bits 129 and 65 set (exact tie), exp 0x3FFF:
  - RNE -> 80'h3FFF_8000000000000000, inexact=1.
  - RUP -> 80'h3FFF_8000000000000001.
  - RDN with sign=1 -> 80'hBFFF_8000000000000001.
- i_exp=0x7FFE, bit130 set:
  - RNE -> 80'h7FFF_8000000000000000, overflow=1, inexact=1.
  - RTZ -> 80'h7FFE_FFFFFFFFFFFFFFFF.
- i_nan=1, info=6, sign=0 -> 80'h7FFF_C000000000000006, flags 0.
  - FPWID=64 variant (EMSB=10, FMSB=51, EXPLICIT_INT=0) -> 64'h7FF8000000000006.
- Backpressure and reset:
  - Stream 6 distinct operands back to back; hold o_ready low for 4 cycles starting cycle 2.
  - i_ready drops once 3 results are buffered; all 6 results emerge in order with no duplicates.
  - Pull rst_n low mid-stream: o_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/fpn_normround_pipe.sv
// fpn_normround_pipe: three-stage normalise/round/pack pipeline with valid/ready flow control.
module fpn_normround_pipe #(
  parameter int FPWID = 80,
  parameter int EMSB = 14,
  parameter int FMSB = 63,
  parameter int EXPLICIT_INT = 1,
  parameter int FX = (FMSB + 2) * 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_sign,
  input  logic [EMSB+1:0]  i_exp,
  input  logic [FX:0]      i_sig,
  input  logic             i_nan,
  input  logic [3:0]       i_nan_info,
  input  logic [2:0]       i_rm,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [FPWID-1:0] o_res,
  output logic             o_inexact,
  output logic             o_overflow,
  output logic             o_underflow
);
  localparam int EW = EMSB + 3;
  localparam int LW = $clog2(FX + 1);
  localparam int MW = FMSB + 1 + (EXPLICIT_INT != 0 ? 0 : 1);
  localparam int LO = FX - MW;
  localparam logic [EMSB:0] ETOP = '1;
  localparam logic [EMSB:0] EBIG = ETOP - 1'b1;
  localparam logic [EW-1:0] EMAX = EW'(ETOP);
  typedef struct packed {
    logic       sign;
    logic       nan;
    logic [3:0] info;
    logic [2:0] rm;
  } ctl_t;
  logic v1, v2, v3, adv1, adv2, adv3;
  ctl_t c1, c2;
  logic [FX-1:0] sig0, sig1, sig2, sig2n;
  logic [EW-1:0] exp0, exp1, exp2, exp2n, lim, sh, ex, ex3;
  logic stk0, stk1, stk2;
  logic [LW-1:0] lz0, lz1;
  logic g, st, up, rne, toinf, ovf;
  logic [MW:0] rnd;
  logic [MW-1:0] man;
  logic [FMSB:0] inf_sig, nan_sig;
  logic [FPWID-1:0] res_n;
  logic inex_n, ovf_n, unf_n;
  assign adv3 = !v3 || o_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign i_ready = adv1;
  assign o_valid = v3;
  // carry fold and leading-zero count
  always_comb begin
    sig0 = i_sig[FX] ? i_sig[FX:1] : i_sig[FX-1:0];
    exp0 = EW'(i_exp) + EW'(i_sig[FX]);
    stk0 = i_sig[FX] & i_sig[0];
    lz0 = LW'(FX);
    for (int i = 0; i < FX; i++) lz0 = sig0[i] ? LW'(FX - 1 - i) : lz0;
  end
  // shift never takes the exponent below 1, leaving a denormal when the lead bit stays clear
  always_comb begin
    lim = exp1 == '0 ? '0 : exp1 - EW'(1);
    sh = EW'(lz1) < lim ? EW'(lz1) : lim;
    sig2n = sig1 << sh;
    exp2n = sig2n[FX-1] ? exp1 - sh : '0;
  end
  always_comb begin
    rne = c2.rm == 3'd0 || c2.rm > 3'd4;
    g = sig2[LO-1];
    st = |sig2[LO-2:0] | stk2;
    up = rne ? g & (st | sig2[LO]) : c2.rm == 3'd4 ? g : c2.rm == 3'd3 ? (g | st) & ~c2.sign : c2.rm == 3'd2 ? (g | st) & c2.sign : 1'b0;
    rnd = {1'b0, sig2[FX-1:LO]} + (MW+1)'(up);
    man = rnd[MW] ? rnd[MW:1] : rnd[MW-1:0];
    ex = exp2 + EW'(rnd[MW]);
    ex3 = (ex == '0 && man[MW-1]) ? EW'(1) : ex;
    ovf = ex3 >= EMAX;
    toinf = rne || c2.rm == 3'd4 || (c2.rm == 3'd3 && !c2.sign) || (c2.rm == 3'd2 && c2.sign);
    inf_sig = '0;
    inf_sig[FMSB] = EXPLICIT_INT != 0;
    nan_sig = '0;
    nan_sig[FMSB] = 1'b1;
    nan_sig[FMSB-1] = EXPLICIT_INT != 0;
    nan_sig[3:0] = c2.info;
    res_n = c2.nan ? {c2.sign, ETOP, nan_sig}
          : ovf ? {c2.sign, toinf ? ETOP : EBIG, toinf ? inf_sig : {(FMSB+1){1'b1}}}
          : {c2.sign, ex3[EMSB:0], man[FMSB:0]};
    inex_n = !c2.nan && (ovf || g || st);
    ovf_n = !c2.nan && ovf;
    unf_n = !c2.nan && !ovf && ex3 == '0 && (g || st);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      o_res <= '0;
      o_inexact <= 1'b0;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (adv1) v1 <= i_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
      if (adv3 && v2) begin
        o_res <= res_n;
        o_inexact <= inex_n;
        o_overflow <= ovf_n;
        o_underflow <= unf_n;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (adv1 && i_valid) begin
      sig1 <= sig0;
      exp1 <= exp0;
      stk1 <= stk0;
      lz1 <= lz0;
      c1 <= {i_sign, i_nan, i_nan_info, i_rm};
    end
    if (adv2 && v1) begin
      sig2 <= sig2n;
      exp2 <= exp2n;
      stk2 <= stk1;
      c2 <= c1;
    end
  end
endmodule

// File: tb/tb_fpn_normround_pipe.sv
// tb_fpn_normround_pipe: randomized scoreboard check of the FP80 pipeline plus FP64 hidden-bit spot checks.
module tb_fpn_normround_pipe;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic i_valid, i_ready, i_sign, i_nan, o_valid, o_ready, o_inexact, o_overflow, o_underflow;
  logic [15:0] i_exp;
  logic [130:0] i_sig;
  logic [3:0] i_info;
  logic [2:0] i_rm;
  logic [79:0] o_res;
  logic b_valid, b_ready, b_sign, b_nan, b_ovalid, b_inex, b_ovf, b_unf;
  logic [11:0] b_exp;
  logic [106:0] b_sig;
  logic [3:0] b_info;
  logic [2:0] b_rm;
  logic [63:0] b_res;
  int n_tests = 0, n_fail = 0, nout = 0, nin = 0;
  logic [82:0] q[$];
  localparam logic [130:0] B0 = 131'd1, B65 = 131'd1 << 65, B128 = 131'd1 << 128;
  localparam logic [130:0] B129 = 131'd1 << 129, B130 = 131'd1 << 130;

  fpn_normround_pipe dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_sign(i_sign),
    .i_exp(i_exp), .i_sig(i_sig), .i_nan(i_nan), .i_nan_info(i_info), .i_rm(i_rm),
    .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res), .o_inexact(o_inexact),
    .o_overflow(o_overflow), .o_underflow(o_underflow));

  fpn_normround_pipe #(.FPWID(64), .EMSB(10), .FMSB(51), .EXPLICIT_INT(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_ready(b_ready), .i_sign(b_sign),
    .i_exp(b_exp), .i_sig(b_sig), .i_nan(b_nan), .i_nan_info(b_info), .i_rm(b_rm),
    .o_valid(b_ovalid), .o_ready(1'b1), .o_res(b_res), .o_inexact(b_inex),
    .o_overflow(b_ovf), .o_underflow(b_unf));

  // Value-level FP80 reference: place the mantissa by the position of the top set bit,
  // clamp tiny values to the denormal scale, then round. Returns {res, inexact, overflow, underflow}.
  function automatic logic [82:0] model(input logic sg, input logic [15:0] ex, input logic [130:0] sig,
                                        input logic nan, input logic [3:0] info, input logic [2:0] rm);
    logic [255:0] s, m;
    int p, e, r, x, mode;
    logic g, st, up, toinf;
    if (nan) return {sg, 15'h7FFF, 2'b11, 58'd0, info, 3'b000};
    if (sig == 0) return {sg, 79'd0, 3'b000};
    s = 256'(sig);
    p = 0;
    for (int i = 0; i < 131; i++) if (s[i]) p = i;
    e = int'(ex) + p - 129;
    r = (e >= 1) ? p - 63 : 67 - int'(ex);
    if (r <= 0) begin
      m = s << (-r); g = 0; st = 0;
    end else begin
      m = s >> r; g = s[r-1]; st = |(s & ((256'd1 << (r - 1)) - 1));
    end
    mode = (rm > 4) ? 0 : int'(rm);
    case (mode)
      0: up = g && (st || m[0]);
      1: up = 0;
      2: up = (g || st) && sg;
      3: up = (g || st) && !sg;
      default: up = g;
    endcase
    m = m + 256'(up);
    x = (e >= 1) ? e : 0;
    if (m[64]) begin m = m >> 1; x++; end
    if (x == 0 && m[63]) x = 1;
    if (x >= 32'h7FFF) begin
      toinf = mode == 0 || mode == 4 || (mode == 3 && !sg) || (mode == 2 && sg);
      return toinf ? {sg, 15'h7FFF, 64'h8000_0000_0000_0000, 3'b110} : {sg, 15'h7FFE, {64{1'b1}}, 3'b110};
    end
    return {sg, 15'(x), m[63:0], g || st, 1'b0, x == 0 && (g || st)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic bad(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      nin = nout;
    end else begin
      if (o_valid && o_ready) begin
        nout++;
        if (q.size() == 0) bad("unexpected_output");
        else chk("result", 128'({o_res, o_inexact, o_overflow, o_underflow}), 128'(q.pop_front()));
      end
      if (i_valid && i_ready) begin
        nin++;
        q.push_back(model(i_sign, i_exp, i_sig, i_nan, i_info, i_rm));
      end
    end
  end

  task automatic put(input logic s, input logic [15:0] e, input logic [130:0] g, input logic n,
                     input logic [3:0] f, input logic [2:0] r);
    int k;
    i_sign = s; i_exp = e; i_sig = g; i_nan = n; i_info = f; i_rm = r; i_valid = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!i_ready && k < 100);
    if (!i_ready) bad("accept");
    @(posedge clk); #2;
    i_valid = 0;
  endtask

  task automatic dir(input string nm, input logic s, input logic [15:0] e, input logic [130:0] g,
                     input logic n, input logic [3:0] f, input logic [2:0] r, input logic [82:0] want);
    int k;
    chk({nm, "_model"}, 128'(model(s, e, g, n, f, r)), 128'(want));
    put(s, e, g, n, f, r);
    k = 0;
    do begin @(negedge clk); k++; end while (!o_valid && k < 10);
    chk({nm, "_latency"}, 128'(k), 128'd3);
    @(posedge clk); #2;
  endtask

  task automatic rand_op();
    logic [255:0] s;
    int p, k;
    s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    p = ($urandom % 4 == 0) ? int'($urandom_range(0, 130)) : int'($urandom_range(128, 130));
    s = s & ((256'd1 << (p + 1)) - 1);
    s[p] = 1;
    if ($urandom % 3 == 0) begin
      k = int'($urandom_range(0, p));
      s = s & ~((256'd1 << k) - 1);
    end
    if ($urandom % 30 == 0) s = 0;
    i_sig = s[130:0];
    case ($urandom % 4)
      0: i_exp = 16'($urandom_range(1, 80));
      1: i_exp = 16'($urandom_range(16'h7FF0, 16'h8003));
      default: i_exp = 16'($urandom_range(1, 16'h7FFE));
    endcase
    i_rm = 3'($urandom);
    i_sign = 1'($urandom);
    i_nan = ($urandom % 16 == 0);
    i_info = 4'($urandom_range(1, 6));
  endtask

  task automatic b_run(input string nm, input logic [11:0] e, input logic [106:0] g, input logic n,
                       input logic [3:0] f, input logic [2:0] r, input logic [63:0] want);
    int k;
    b_sign = 0; b_exp = e; b_sig = g; b_nan = n; b_info = f; b_rm = r; b_valid = 1;
    @(negedge clk);
    @(posedge clk); #2;
    b_valid = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!b_ovalid && k < 10);
    if (!b_ovalid) bad({nm, "_valid"});
    else chk(nm, 128'(b_res), 128'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int sent, n0, k;
    logic low, pend;
    i_valid = 0; i_sign = 0; i_exp = 0; i_sig = 0; i_nan = 0; i_info = 0; i_rm = 0; o_ready = 1;
    b_valid = 0; b_sign = 0; b_exp = 0; b_sig = 0; b_nan = 0; b_info = 0; b_rm = 0;
    repeat (3) @(negedge clk);
    chk("rst_ovalid", 128'(o_valid), 0);
    chk("rst_res", 128'({o_res, o_inexact, o_overflow, o_underflow}), 0);
    @(posedge clk); #2;
    rst_n = 1;
    @(negedge clk);
    chk("rst_iready", 128'(i_ready), 1);
    @(posedge clk); #2;

    dir("one", 0, 16'h3FFF, B129, 0, 0, 0, {80'h3FFF_8000_0000_0000_0000, 3'b000});
    dir("two", 0, 16'h3FFF, B130, 0, 0, 0, {80'h4000_8000_0000_0000_0000, 3'b000});
    dir("tie_rne", 0, 16'h3FFF, B129 | B65, 0, 0, 0, {80'h3FFF_8000_0000_0000_0000, 3'b100});
    dir("tie_rup", 0, 16'h3FFF, B129 | B65, 0, 0, 3, {80'h3FFF_8000_0000_0000_0001, 3'b100});
    dir("tie_rdn", 1, 16'h3FFF, B129 | B65, 0, 0, 2, {80'hBFFF_8000_0000_0000_0001, 3'b100});
    dir("tie_rmm", 0, 16'h3FFF, B129 | B65, 0, 0, 4, {80'h3FFF_8000_0000_0000_0001, 3'b100});
    dir("ovf_rne", 0, 16'h7FFE, B130, 0, 0, 0, {80'h7FFF_8000_0000_0000_0000, 3'b110});
    dir("ovf_rtz", 0, 16'h7FFE, B130, 0, 0, 1, {80'h7FFE_FFFF_FFFF_FFFF_FFFF, 3'b110});
    dir("ovf_rdn_pos", 0, 16'h7FFE, B130, 0, 0, 2, {80'h7FFE_FFFF_FFFF_FFFF_FFFF, 3'b110});
    dir("ovf_rup_pos", 0, 16'h7FFE, B130, 0, 0, 3, {80'h7FFF_8000_0000_0000_0000, 3'b110});
    dir("nan", 0, 16'h0000, B129, 1, 6, 0, {80'h7FFF_C000_0000_0000_0006, 3'b000});
    dir("denorm", 0, 16'h0001, B128, 0, 0, 0, {80'h0000_4000_0000_0000_0000, 3'b000});
    dir("denorm_unf", 0, 16'h0001, B128 | B0, 0, 0, 0, {80'h0000_4000_0000_0000_0000, 3'b101});
    dir("neg_zero", 1, 16'h3FFF, 131'd0, 0, 0, 0, {80'h8000_0000_0000_0000_0000, 3'b000});

    b_run("fp64_nan", 12'h000, 107'd0, 1, 6, 0, 64'h7FF8_0000_0000_0006);
    b_run("fp64_one", 12'h3FF, 107'd1 << 105, 0, 0, 0, 64'h3FF0_0000_0000_0000);
    b_run("fp64_rup", 12'h3FF, (107'd1 << 105) | (107'd1 << 52), 0, 0, 3, 64'h3FF0_0000_0000_0001);
    b_run("fp64_two", 12'h3FF, 107'd1 << 106, 0, 0, 0, 64'h4000_0000_0000_0000);
    @(posedge clk); #2;

    // six back-to-back operands with the sink stalled for four cycles
    sent = 0; low = 0; n0 = nout;
    for (int c = 0; c < 20; c++) begin
      o_ready = !(c >= 2 && c < 6);
      if (sent < 6) begin
        i_sign = 0; i_exp = 16'(16'h3FF0 + sent); i_sig = B129 | (131'(sent + 1) << 70);
        i_nan = 0; i_rm = 0; i_valid = 1;
      end else i_valid = 0;
      #1 chk("bp_ready", 128'(i_ready), 128'(!(nin - nout == 3 && !o_ready)));
      if (!i_ready) low = 1;
      @(negedge clk);
      if (i_valid && i_ready) sent++;
      @(posedge clk); #2;
    end
    chk("bp_ready_dropped", 128'(low), 1);
    chk("bp_outputs", 128'(nout - n0), 6);

    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        if ($urandom % 4 != 0) begin rand_op(); i_valid = 1; pend = 1; end
        else i_valid = 0;
      end
      o_ready = ($urandom % 4 != 0);
      #1 chk("rand_ready", 128'(i_ready), 128'(!(nin - nout == 3 && !o_ready)));
      @(negedge clk);
      if (i_valid && i_ready) pend = 0;
      @(posedge clk); #2;
    end
    i_valid = 0; o_ready = 1;
    k = 0;
    while (q.size() != 0 && k < 20) begin @(posedge clk); k++; end
    chk("drain", 128'(q.size()), 0);
    @(posedge clk); #2;

    for (int c = 0; c < 5; c++) begin
      rand_op(); i_nan = 0; i_valid = 1;
      @(posedge clk); #2;
    end
    #1 rst_n = 0;
    #1 chk("midrst_ovalid", 128'(o_valid), 0);
    chk("midrst_res", 128'(o_res), 0);
    i_valid = 0;
    n0 = nout;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (8) @(posedge clk);
    chk("midrst_no_stale", 128'(nout - n0), 0);
    chk("midrst_idle", 128'({o_valid, i_ready}), 128'(2'b01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
